// File: rtl/ptr_sync_pkg.sv
// Shared types and helpers for the gray-pointer synchroniser family.
// Width-generic conversions operate on a 32-bit container masked to the live width.
package ptr_sync_pkg;

    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 8;
    localparam int PTR_MAX_W  = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_max_t;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } sync_state_t;

    function automatic ptr_max_t width_mask(input int width);
        ptr_max_t m;
        m = '0;
        for (int i = 0; i < PTR_MAX_W; i++) begin
            if (i < width) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Binary bit i is the XOR of all gray bits at or above i.
    function automatic ptr_max_t gray2bin(input ptr_max_t g, input int width);
        ptr_max_t gm;
        ptr_max_t b;
        gm = g & width_mask(width);
        b  = gm;
        for (int i = 1; i < PTR_MAX_W; i++) begin
            b = b ^ (gm >> i);
        end
        return b;
    endfunction

    function automatic ptr_max_t bin2gray(input ptr_max_t b, input int width);
        ptr_max_t bm;
        bm = b & width_mask(width);
        return bm ^ (bm >> 1);
    endfunction

endpackage

// File: rtl/ptr_sync_sync_chain.sv
// Generic WIDTH x STAGES synchroniser flop chain with asynchronous active-high reset.
// Reused for both pointer directions and for single-bit control crossings.
module sync_chain
    import ptr_sync_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("sync_chain: STAGES must be within 2..8");
    end

    // First stage is the metastability catcher; CDC tooling keys off this attribute.
    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] meta;
    logic [STAGES-2:0][WIDTH-1:0] settle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= '0;
            settle <= '0;
        end else begin
            meta      <= d;
            settle[0] <= meta;
            for (int i = 1; i < STAGES - 1; i++) begin
                settle[i] <= settle[i-1];
            end
        end
    end

    assign q = settle[STAGES-2];

endmodule

// File: rtl/ptr_sync.sv
// Gray pointer synchroniser into rclk with binary conversion, per-cycle advance and
// warm-up gating. Optional jump checker enabled by PTR_SYNC_JUMP_CHK_EN.
module ptr_sync
    import ptr_sync_pkg::*;
#(
    parameter int ADDRSIZE = 4,
    parameter int STAGES   = 2
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   gptr,
    input  logic                err_clr,
    output logic [ADDRSIZE:0]   sync_gray,
    output logic [ADDRSIZE:0]   sync_bin,
    output logic [ADDRSIZE:0]   delta,
    output logic                moved,
    output logic                sync_vld,
    output logic                err
);

    localparam int W     = ADDRSIZE + 1;
    localparam int DEPTH = 1 << ADDRSIZE;
    localparam int CNT_W = $clog2(STAGES + 2);
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(STAGES);

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("ptr_sync: STAGES must be within 2..8");
    end
    if (ADDRSIZE < 1 || ADDRSIZE > PTR_MAX_W - 2) begin : g_bad_addrsize
        $error("ptr_sync: ADDRSIZE out of supported range");
    end

    sync_state_t      state;
    logic [CNT_W-1:0] warm_cnt;
    logic [W-1:0]     new_bin;
    logic [W-1:0]     delta_next;

    sync_chain #(
        .WIDTH  (W),
        .STAGES (STAGES)
    ) u_gray_sync (
        .clk (rclk),
        .rst (rrst),
        .d   (gptr),
        .q   (sync_gray)
    );

    always_comb begin
        new_bin    = W'(gray2bin(ptr_max_t'(sync_gray), W));
        delta_next = new_bin - sync_bin;
    end

    // sync_bin tracks from the first edge so the previous-bin register is settled
    // by the time RUN starts reporting deltas.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state    <= WARM;
            warm_cnt <= '0;
            sync_bin <= '0;
            delta    <= '0;
            moved    <= 1'b0;
            sync_vld <= 1'b0;
        end else begin
            sync_bin <= new_bin;
            case (state)
                WARM: begin
                    delta    <= '0;
                    moved    <= 1'b0;
                    warm_cnt <= warm_cnt + 1'b1;
                    if (warm_cnt == WARM_LAST) begin
                        state    <= RUN;
                        sync_vld <= 1'b1;
                    end
                end
                RUN: begin
                    delta <= delta_next;
                    moved <= |delta_next;
                end
                default: begin
                    state    <= WARM;
                    warm_cnt <= '0;
                    sync_vld <= 1'b0;
                end
            endcase
        end
    end

`ifdef PTR_SYNC_JUMP_CHK_EN
    logic jump;

    assign jump = (state == RUN) && (delta_next > W'(DEPTH));

    // A fresh violation outranks a clear arriving on the same edge.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            err <= 1'b0;
        end else if (jump) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_ptr_sync.sv
// Self-checking bench for ptr_sync (ADDRSIZE=4, STAGES=2) against a sample-history model.
module tb_ptr_sync;

    localparam int ADDRSIZE = 4;
    localparam int STAGES   = 2;
    localparam int W        = ADDRSIZE + 1;
    localparam int DEPTH    = 16;
`ifdef PTR_SYNC_JUMP_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         rclk = 1'b0;
    logic         rrst;
    logic [W-1:0] gptr;
    logic         err_clr;
    logic [W-1:0] sync_gray;
    logic [W-1:0] sync_bin;
    logic [W-1:0] delta;
    logic         moved;
    logic         sync_vld;
    logic         err;

    int checks = 0;
    int errors = 0;

    // Model state: gptr as sampled on each edge since reset release.
    logic [W-1:0] hist[$];
    int           edges;
    logic         err_m;
    logic [W-1:0] exp_gray, exp_bin, exp_delta;
    logic         exp_moved, exp_vld, exp_err;

    ptr_sync #(.ADDRSIZE(ADDRSIZE), .STAGES(STAGES)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .gptr      (gptr),
        .err_clr   (err_clr),
        .sync_gray (sync_gray),
        .sync_bin  (sync_bin),
        .delta     (delta),
        .moved     (moved),
        .sync_vld  (sync_vld),
        .err       (err)
    );

    always #5 rclk = ~rclk;

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Inverse by search: the binary value whose gray code matches.
    function automatic logic [W-1:0] to_bin(input logic [W-1:0] g);
        for (int b = 0; b < (1 << W); b++) begin
            logic [W-1:0] bb;
            bb = W'(b);
            if (to_gray(bb) == g) return bb;
        end
        return '0;
    endfunction

    function automatic logic [W-1:0] sample_at(input int m);
        return (m >= 1) ? hist[m-1] : '0;
    endfunction

    task automatic reset_model();
        hist.delete();
        edges     = 0;
        err_m     = 1'b0;
        exp_gray  = '0;
        exp_bin   = '0;
        exp_delta = '0;
        exp_moved = 1'b0;
        exp_vld   = 1'b0;
        exp_err   = 1'b0;
    endtask

    task automatic tick();
        logic [W-1:0] g_s;
        logic         clr_s, rst_s;
        g_s   = gptr;
        clr_s = err_clr;
        rst_s = rrst;
        @(posedge rclk);
        #1;
        if (rst_s) begin
            reset_model();
        end else begin
            hist.push_back(g_s);
            edges++;
            exp_gray = sample_at(edges - STAGES + 1);
            exp_bin  = to_bin(sample_at(edges - STAGES));
            exp_vld  = (edges >= STAGES + 1);
            if (edges >= STAGES + 2)
                exp_delta = to_bin(sample_at(edges - STAGES)) - to_bin(sample_at(edges - STAGES - 1));
            else
                exp_delta = '0;
            exp_moved = (exp_delta != 0);
            if (CHK && edges >= STAGES + 2 && exp_delta > DEPTH) err_m = 1'b1;
            else if (clr_s) err_m = 1'b0;
            exp_err = err_m;
        end
    endtask

    task automatic restart(input logic [W-1:0] g);
        rrst    = 1'b1;
        gptr    = g;
        err_clr = 1'b0;
        tick();
        rrst = 1'b0;
        repeat (STAGES + 2) tick();
    endtask

    task automatic test_reset();
        rrst    = 1'b1;
        gptr    = 5'b00110;
        err_clr = 1'b0;
        #2;
        reset_model();
        tick();
        tick();
        checks++;
        if ({sync_gray, sync_bin, delta, moved, sync_vld, err} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h want 0",
                     {sync_gray, sync_bin, delta, moved, sync_vld, err});
        end
        rrst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (sync_vld !== (k == 3)) begin
                errors++;
                $display("[TB] FAIL reset_vld_edge%0d got %b want %b", k, sync_vld, (k == 3));
            end
        end
        checks++;
        if (delta !== 5'd0 || err !== 1'b0 || sync_bin !== 5'd4) begin
            errors++;
            $display("[TB] FAIL reset_release got delta=%0d err=%b bin=%0d want 0 0 4",
                     delta, err, sync_bin);
        end
    endtask

    task automatic test_latency();
        restart(5'b00000);
        gptr = 5'b00001;
        tick();
        checks++;
        if (sync_gray !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL lat_gray_early got %b want 00000", sync_gray);
        end
        tick();
        checks++;
        if (sync_gray !== 5'b00001 || sync_bin !== 5'd0) begin
            errors++;
            $display("[TB] FAIL lat_gray got %b/%0d want 00001/0", sync_gray, sync_bin);
        end
        tick();
        checks++;
        if (sync_bin !== 5'd1 || delta !== 5'd1 || moved !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lat_bin got bin=%0d delta=%0d moved=%b want 1 1 1",
                     sync_bin, delta, moved);
        end
        tick();
        checks++;
        if (moved !== 1'b0 || delta !== 5'd0) begin
            errors++;
            $display("[TB] FAIL lat_moved_drop got moved=%b delta=%0d want 0 0", moved, delta);
        end
    endtask

    task automatic test_multi_step();
        restart(5'b00000);
        gptr = 5'b00010;
        repeat (3) tick();
        checks++;
        if (delta !== 5'd3 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL multi_step got delta=%0d err=%b want 3 0", delta, err);
        end
        tick();
        checks++;
        if (delta !== 5'd0) begin
            errors++;
            $display("[TB] FAIL multi_step_once got delta=%0d want 0", delta);
        end
    endtask

    task automatic test_wrap();
        restart(5'b10000);
        gptr = 5'b00001;
        repeat (3) tick();
        checks++;
        if (delta !== 5'd2 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_31_1 got delta=%0d err=%b want 2 0", delta, err);
        end
        restart(5'b00000);
        gptr = 5'b11000;
        repeat (3) tick();
        checks++;
        if (delta !== 5'd16 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_full got delta=%0d err=%b want 16 0", delta, err);
        end
    endtask

    task automatic test_jump_error();
        restart(5'b00000);
        gptr = 5'b11110;
        repeat (3) tick();
        checks++;
        if (delta !== 5'd20 || err !== CHK) begin
            errors++;
            $display("[TB] FAIL jump_set got delta=%0d err=%b want 20 %b", delta, err, CHK);
        end
        repeat (2) tick();
        checks++;
        if (err !== CHK) begin
            errors++;
            $display("[TB] FAIL jump_hold got %b want %b", err, CHK);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL jump_clear got %b want 0", err);
        end
        // bin 20 -> 8 is an advance of 20 again; the clear lands on the same edge.
        gptr = 5'b01100;
        repeat (2) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (delta !== 5'd20 || err !== CHK) begin
            errors++;
            $display("[TB] FAIL jump_set_wins got delta=%0d err=%b want 20 %b", delta, err, CHK);
        end
    endtask

    task automatic test_warmup_live();
        rrst    = 1'b1;
        gptr    = 5'b11110;
        err_clr = 1'b0;
        tick();
        rrst = 1'b0;
        repeat (3) tick();
        checks++;
        if (sync_vld !== 1'b1 || sync_bin !== 5'd20 || delta !== 5'd0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL warm_live got vld=%b bin=%0d delta=%0d err=%b want 1 20 0 0",
                     sync_vld, sync_bin, delta, err);
        end
        tick();
        checks++;
        if (delta !== 5'd0 || moved !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL warm_live_run got delta=%0d moved=%b err=%b want 0 0 0",
                     delta, moved, err);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] cur_b;
        restart(5'b00000);
        cur_b = '0;
        for (int it = 0; it < 400; it++) begin
            if (it == 200) begin
                // Asynchronous reset between edges must clear outputs immediately.
                @(negedge rclk);
                rrst = 1'b1;
                #1;
                checks++;
                if ({sync_gray, sync_bin, delta, moved, sync_vld, err} !== '0) begin
                    errors++;
                    $display("[TB] FAIL rand_async_reset got %h want 0",
                             {sync_gray, sync_bin, delta, moved, sync_vld, err});
                end
                tick();
                rrst = 1'b0;
            end
            if ($urandom_range(0, 3) == 0)
                cur_b = W'($urandom_range(0, (1 << W) - 1));
            else
                cur_b = cur_b + W'($urandom_range(0, 3));
            gptr    = to_gray(cur_b);
            err_clr = ($urandom_range(0, 7) == 0);
            tick();
            checks++;
            if (sync_gray !== exp_gray) begin
                errors++;
                $display("[TB] FAIL rand_gray it=%0d got %b want %b", it, sync_gray, exp_gray);
            end
            checks++;
            if (sync_bin !== exp_bin) begin
                errors++;
                $display("[TB] FAIL rand_bin it=%0d got %0d want %0d", it, sync_bin, exp_bin);
            end
            checks++;
            if (delta !== exp_delta || moved !== exp_moved) begin
                errors++;
                $display("[TB] FAIL rand_delta it=%0d got %0d/%b want %0d/%b",
                         it, delta, moved, exp_delta, exp_moved);
            end
            checks++;
            if (sync_vld !== exp_vld || err !== exp_err) begin
                errors++;
                $display("[TB] FAIL rand_flags it=%0d got vld=%b err=%b want %b %b",
                         it, sync_vld, err, exp_vld, exp_err);
            end
        end
        err_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_multi_step();
        test_wrap();
        test_jump_error();
        test_warmup_live();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
